// File: rtl/adder_tree_accumulator.sv
//============================================================================
// Module      : adder_tree_accumulator
// Description : Sums NUM_SAMPLES accepted adder-tree results into one block
//               total and holds it on a valid/ready output handshake.
//               Define ADDER_TREE_ACC_SATURATE_EN to clamp instead of wrap.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module adder_tree_accumulator #(
   parameter int ADDER_WIDTH    = 15,
   parameter int NUM_SAMPLES    = 16,
   parameter int ACC_EXTRA_BITS = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [ADDER_WIDTH:0]                  in_sum,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [ADDER_WIDTH+ACC_EXTRA_BITS:0]   acc_out,
   output logic [7:0]                            sample_cnt,
   output logic                                  ovf
);

   localparam int         ACC_W      = ADDER_WIDTH + 1 + ACC_EXTRA_BITS;
   localparam logic [7:0] c_LAST_IDX = 8'(NUM_SAMPLES - 1);

   localparam logic [0:0] c_ACCUM = 1'b0;
   localparam logic [0:0] c_HOLD  = 1'b1;

   logic [0:0]       state_q, state_d;

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] acc_out_q, acc_out_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             ovf_q, ovf_d;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_first;
   logic             w_last;
   logic             w_release;
   logic [ACC_W-1:0] w_in_ext;
   logic [ACC_W:0]   w_sum;
   logic             w_carry;
   logic [ACC_W-1:0] w_acc_next;

   assign w_accept  = in_valid && w_in_ready;
   assign w_first   = (cnt_q == 8'd0);
   assign w_last    = (cnt_q == c_LAST_IDX);
   assign w_release = (state_q == c_HOLD) && out_valid_q && out_ready;

   assign w_in_ext  = ACC_W'(in_sum);
   assign w_sum     = {1'b0, acc_q} + {1'b0, w_in_ext};
   // The first sample of a block replaces acc, so it can never carry.
   assign w_carry   = !w_first && w_sum[ACC_W];

`ifdef ADDER_TREE_ACC_SATURATE_EN
   assign w_acc_next = w_first ? w_in_ext :
                       (w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0]);
`else
   assign w_acc_next = w_first ? w_in_ext : w_sum[ACC_W-1:0];
`endif

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= c_ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ACCUM: if (w_accept && w_last) state_d = c_HOLD;
         c_HOLD:  if (w_release)          state_d = c_ACCUM;
         default:                         state_d = c_ACCUM;
      endcase
   end

   // FSM: outputs (in_ready is the only unregistered output)
   always_comb begin
      w_in_ready = 1'b0;
      if ((state_q == c_ACCUM) && !rst) begin
         w_in_ready = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath next-state
   // ---------------------------------------------------------------------
   always_comb begin
      acc_d       = acc_q;
      acc_out_d   = acc_out_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      ovf_d       = ovf_q;

      if (w_accept) begin
         acc_d = w_acc_next;
         ovf_d = w_first ? 1'b0 : (ovf_q | w_carry);
         if (w_last) begin
            acc_out_d   = w_acc_next;
            out_valid_d = 1'b1;
            cnt_d       = 8'd0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end else if (w_release) begin
         out_valid_d = 1'b0;
         ovf_d       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         acc_out_q   <= '0;
         cnt_q       <= 8'd0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         acc_out_q   <= acc_out_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
      end
   end

   assign in_ready   = w_in_ready;
   assign out_valid  = out_valid_q;
   assign acc_out    = acc_out_q;
   assign sample_cnt = cnt_q;
   assign ovf        = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_tree_accumulator.sv
//============================================================================
// Module      : tb_adder_tree_accumulator
// Description : Directed self-checking bench for adder_tree_accumulator,
//               default build plus a narrow overflow instance.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_adder_tree_accumulator;

   logic        clk = 1'b0;
   logic        rst;

   logic        in_valid, in_ready, out_valid, out_ready, ovf;
   logic [15:0] in_sum;
   logic [19:0] acc_out;
   logic [7:0]  sample_cnt;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
   logic [15:0] b_in_sum;
   logic [15:0] b_acc_out;
   logic [7:0]  b_sample_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   adder_tree_accumulator u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sum     (in_sum),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .acc_out    (acc_out),
      .sample_cnt (sample_cnt),
      .ovf        (ovf)
   );

   adder_tree_accumulator #(
      .ADDER_WIDTH    (15),
      .NUM_SAMPLES    (2),
      .ACC_EXTRA_BITS (0)
   ) u_narrow (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (b_in_valid),
      .in_ready   (b_in_ready),
      .in_sum     (b_in_sum),
      .out_valid  (b_out_valid),
      .out_ready  (b_out_ready),
      .acc_out    (b_acc_out),
      .sample_cnt (b_sample_cnt),
      .ovf        (b_ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      int sent;
      int k;
      logic [31:0] exp_narrow;

      rst = 1'b1; in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_sum = '0; b_out_ready = 1'b0;
      cyc(); cyc();
      check("rst_in_ready",   32'(in_ready), 0);
      check("rst_out_valid",  32'(out_valid), 0);
      check("rst_acc_out",    32'(acc_out), 0);
      check("rst_sample_cnt", 32'(sample_cnt), 0);
      check("rst_ovf",        32'(ovf), 0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 1);

      // 16 back-to-back samples of 1000
      for (int i = 0; i < 16; i++) begin
         if (i == 15) begin
            check("b1_cnt15",   32'(sample_cnt), 15);
            check("b1_ov_pre",  32'(out_valid), 0);
         end
         in_valid = 1'b1; in_sum = 16'd1000;
         cyc();
      end
      in_valid = 1'b0;
      check("b1_out_valid", 32'(out_valid), 1);
      check("b1_acc_out",   32'(acc_out), 16000);
      check("b1_ovf",       32'(ovf), 0);
      check("b1_in_ready",  32'(in_ready), 0);
      check("b1_cnt0",      32'(sample_cnt), 0);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      check("b1_rel_valid", 32'(out_valid), 0);
      check("b1_rel_ready", 32'(in_ready), 1);

      // 16 samples of full-scale value
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_sum = 16'hFFFF;
         cyc();
      end
      in_valid = 1'b0;
      check("b2_out_valid", 32'(out_valid), 1);
      check("b2_acc_out",   32'(acc_out), 1048560);
      check("b2_ovf",       32'(ovf), 0);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;

      // Samples 1..16 with periodic gaps: total 136
      sent = 0; k = 0;
      while (sent < 16) begin
         in_valid = (k % 3) != 1;
         in_sum   = 16'(sent + 1);
         cyc();
         if ((k % 3) != 1) sent++;
         k++;
      end
      check("b3_out_valid", 32'(out_valid), 1);
      check("b3_acc_out",   32'(acc_out), 136);
      // Offer data during HOLD; it must not be taken
      in_valid = 1'b1; in_sum = 16'd500;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("b3_hold_acc",   32'(acc_out), 136);
         check("b3_hold_valid", 32'(out_valid), 1);
         check("b3_hold_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1; in_sum = 16'd7;
      cyc();
      out_ready = 1'b0;
      check("b3_rel_cnt",   32'(sample_cnt), 0);
      check("b3_rel_valid", 32'(out_valid), 0);
      cyc();
      check("b3_first_cnt", 32'(sample_cnt), 1);
      for (int i = 0; i < 15; i++) begin
         in_sum = 16'd2;
         cyc();
      end
      in_valid = 1'b0;
      check("b4_out_valid", 32'(out_valid), 1);
      check("b4_acc_out",   32'(acc_out), 37);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;

      // Narrow instance overflow: 40000 + 40000 in 16 bits
      b_in_valid = 1'b1; b_in_sum = 16'd40000;
      cyc(); cyc();
      b_in_valid = 1'b0;
`ifdef ADDER_TREE_ACC_SATURATE_EN
      exp_narrow = 65535;
`else
      exp_narrow = 14464;
`endif
      check("nar_out_valid", 32'(b_out_valid), 1);
      check("nar_acc_out",   32'(b_acc_out), exp_narrow);
      check("nar_ovf",       32'(b_ovf), 1);
      b_out_ready = 1'b1;
      cyc();
      b_out_ready = 1'b0;
      check("nar_rel_ovf",   32'(b_ovf), 0);
      check("nar_rel_valid", 32'(b_out_valid), 0);

      // Reset mid-block discards the partial total
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; in_sum = 16'd9;
         cyc();
      end
      in_valid = 1'b0;
      check("mid_cnt7", 32'(sample_cnt), 7);
      rst = 1'b1;
      #1;
      check("mid_rst_ready", 32'(in_ready), 0);
      cyc();
      rst = 1'b0;
      check("mid_rst_cnt",   32'(sample_cnt), 0);
      check("mid_rst_valid", 32'(out_valid), 0);
      for (int i = 0; i < 16; i++) begin
         check("mid_no_out", 32'(out_valid), 0);
         in_valid = 1'b1; in_sum = 16'd1;
         cyc();
      end
      in_valid = 1'b0;
      check("mid_out_valid", 32'(out_valid), 1);
      check("mid_acc_out",   32'(acc_out), 16);

      // Reset during HOLD
      rst = 1'b1;
      cyc();
      check("hold_rst_valid", 32'(out_valid), 0);
      check("hold_rst_acc",   32'(acc_out), 0);
      check("hold_rst_ready", 32'(in_ready), 0);
      rst = 1'b0;
      cyc();
      check("hold_rst_ready_after", 32'(in_ready), 1);
      check("hold_rst_cnt",         32'(sample_cnt), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
